// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button debouncer.
// Each channel runs a two-flop synchroniser, then a stability counter that
// accepts a new level only after STABLE_CYCLES consecutive enabled samples
// of it. The filtered level drives registered rise/fall pulses and a hold
// counter that reports a single long_press per press.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1024,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1),
  parameter int HOLD_WIDTH    = $clog2(LONG_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] held_long
);

  // Terminal count of the stability counter and the saturation point of the
  // hold counter, sized to their registers.
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(LONG_CYCLES);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                  s1_q,   s1_d;
    logic                  s2_q,   s2_d;
    logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic                  deb_q,  deb_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  lp_q,   lp_d;
    logic                  held_q, held_d;

    // Next-state logic: synchroniser shift, stability filter, hold tracking.
    always_comb begin
      // NOTE: every signal gets a default before any branch; a path that
      // leaves a combinational output unassigned would infer a latch.
      s1_d   = button[i];
      s2_d   = s1_q;
      cnt_d  = cnt_q;
      hold_d = hold_q;
      deb_d  = deb_q;
      held_d = held_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      lp_d   = 1'b0;

      if (sample_en) begin
        // Stability filter: any sample matching the current level restarts
        // the count, so only an unbroken run of the new level is accepted.
        if (s2_q == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          deb_d  = s2_q;
          rise_d = s2_q;
          fall_d = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        // Hold tracking: a fall wins over the final hold increment, so
        // long_press and fall can never coincide.
        if (fall_d) begin
          hold_d = '0;
          held_d = 1'b0;
        end else if (rise_d) begin
          hold_d = '0;
        end else if (deb_q && (hold_q < HOLD_MAX)) begin
          hold_d = hold_q + HOLD_WIDTH'(1);
          if (hold_d == HOLD_MAX) begin
            lp_d   = 1'b1;
            held_d = 1'b1;
          end
        end
      end
    end

    // Channel state registers with synchronous reset that overrides all updates.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        cnt_q  <= '0;
        hold_q <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        lp_q   <= 1'b0;
        held_q <= 1'b0;
      end else begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        deb_q  <= deb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        lp_q   <= lp_d;
        held_q <= held_d;
      end
    end

    assign debounced[i]  = deb_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign long_press[i] = lp_q;
    assign held_long[i]  = held_q;
  end

endmodule
